// File: rtl/snake_display.sv
// SVGA timing generator that draws the snake head, apple and score bar, and
// reports vblank plus a sticky head/apple collision flag to the update FSM.
module snake_display #(
    parameter int unsigned H_VIS    = 800,
    parameter int unsigned H_SYNC_S = 856,
    parameter int unsigned H_SYNC_E = 976,
    parameter int unsigned H_TOT    = 1040,
    parameter int unsigned V_VIS    = 600,
    parameter int unsigned V_SYNC_S = 637,
    parameter int unsigned V_SYNC_E = 643,
    parameter int unsigned V_TOT    = 666,
    parameter int unsigned OBJ      = 20,
    parameter int unsigned BAR_W    = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [19:0] snake_head,
    input  logic [19:0] apple_pos,
    input  logic        vis_apple,
    input  logic        hCol,
    input  logic [3:0]  points,
    output logic        hsync,
    output logic        vsync,
    output logic [11:0] rgb,
    output logic        is_listening,
    output logic        apple_bite
);

    localparam int unsigned CW    = 11;
    localparam int unsigned BAR_H = 10;

    typedef enum logic {
        CLEAR,
        PENDING
    } bite_state_t;

    logic [CW-1:0] hcnt;
    logic [CW-1:0] vcnt;
    logic [CW-1:0] head_x;
    logic [CW-1:0] head_y;
    logic [CW-1:0] apple_x;
    logic [CW-1:0] apple_y;
    logic [CW-1:0] bar_len;
    logic          visible;
    logic          in_head;
    logic          in_apple;
    logic          in_bar;
    logic          collide;
    logic          frame_start;
    logic          latch_pt;
    logic          hcol_q;
    logic          hcol_rise;
    logic          hit_acc;
    logic [11:0]   pixel;
    bite_state_t   state;

    // Pixel and line counters
    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (hcnt == CW'(H_TOT - 1)) begin
            hcnt <= '0;
            vcnt <= (vcnt == CW'(V_TOT - 1)) ? '0 : vcnt + CW'(1);
        end else begin
            hcnt <= hcnt + CW'(1);
        end
    end

    // 11-bit coordinates so the +OBJ edges cannot wrap
    assign head_x  = CW'(snake_head[19:10]);
    assign head_y  = CW'(snake_head[9:0]);
    assign apple_x = CW'(apple_pos[19:10]);
    assign apple_y = CW'(apple_pos[9:0]);
    assign bar_len = CW'(points) * CW'(BAR_W);

    assign visible  = (hcnt < CW'(H_VIS)) && (vcnt < CW'(V_VIS));
    assign in_head  = (hcnt >= head_x) && (hcnt < head_x + CW'(OBJ)) &&
                      (vcnt >= head_y) && (vcnt < head_y + CW'(OBJ));
    assign in_apple = (hcnt >= apple_x) && (hcnt < apple_x + CW'(OBJ)) &&
                      (vcnt >= apple_y) && (vcnt < apple_y + CW'(OBJ));
    assign in_bar   = (vcnt < CW'(BAR_H)) && (hcnt < bar_len);

    // Collision ignores vis_apple so a blinking apple still gets eaten
    assign collide     = visible && in_head && in_apple;
    assign frame_start = (hcnt == '0) && (vcnt == '0);
    assign latch_pt    = (hcnt == '0) && (vcnt == CW'(V_VIS));
    assign hcol_rise   = hCol && !hcol_q;

    always_comb begin
        pixel = 12'h000;
        if (visible) begin
            if (in_head) begin
                pixel = 12'h0F0;
            end else if (in_apple && vis_apple) begin
                pixel = 12'hF00;
            end else if (in_bar) begin
                pixel = 12'hFFF;
            end
        end
    end

    // Video outputs, all one clock behind the counters
    always_ff @(posedge clk) begin
        if (rst) begin
            hsync        <= 1'b0;
            vsync        <= 1'b0;
            rgb          <= 12'h000;
            is_listening <= 1'b0;
        end else begin
            hsync        <= (hcnt >= CW'(H_SYNC_S)) && (hcnt < CW'(H_SYNC_E));
            vsync        <= (vcnt >= CW'(V_SYNC_S)) && (vcnt < CW'(V_SYNC_E));
            rgb          <= pixel;
            is_listening <= (vcnt >= CW'(V_VIS));
        end
    end

    // Collision accumulator and apple_bite handshake; hCol clear beats the latch
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= CLEAR;
            apple_bite <= 1'b0;
            hit_acc    <= 1'b0;
            hcol_q     <= 1'b1;
        end else begin
            hcol_q <= hCol;
            if (frame_start) begin
                hit_acc <= collide;
            end else if (collide) begin
                hit_acc <= 1'b1;
            end
            case (state)
                CLEAR: begin
                    if (latch_pt) begin
                        if (hcol_rise) begin
                            hit_acc <= 1'b0;
                        end else if (hit_acc) begin
                            state      <= PENDING;
                            apple_bite <= 1'b1;
                        end
                    end
                end
                PENDING: begin
                    if (hcol_rise) begin
                        state      <= CLEAR;
                        apple_bite <= 1'b0;
                        hit_acc    <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snake_display.sv
// Scoreboard bench for snake_display on a shrunken raster (56x36 clocks/frame)
// so several frames fit in a short run; expectations are keyed by clock number.
module tb_snake_display;

    localparam int unsigned H   = 56;
    localparam int unsigned VV  = 30;
    localparam int unsigned F   = 56 * 36;
    localparam int unsigned LAT = VV * H + 1;

    localparam int SIG_HS = 0;
    localparam int SIG_VS = 1;
    localparam int SIG_RGB = 2;
    localparam int SIG_LIS = 3;
    localparam int SIG_BITE = 4;

    typedef struct {
        int unsigned cyc;
        int          sig;
        logic [11:0] exp;
        string       name;
    } chk_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [19:0] snake_head;
    logic [19:0] apple_pos;
    logic        vis_apple;
    logic        hCol;
    logic [3:0]  points;
    logic        hsync;
    logic        vsync;
    logic [11:0] rgb;
    logic        is_listening;
    logic        apple_bite;

    chk_t        sb[$];
    int unsigned cyc = 0;
    int          total = 0;
    int          bad = 0;

    snake_display #(
        .H_VIS(40), .H_SYNC_S(44), .H_SYNC_E(50), .H_TOT(56),
        .V_VIS(30), .V_SYNC_S(32), .V_SYNC_E(34), .V_TOT(36),
        .OBJ(4), .BAR_W(2)
    ) dut (
        .clk(clk), .rst(rst), .snake_head(snake_head), .apple_pos(apple_pos),
        .vis_apple(vis_apple), .hCol(hCol), .points(points), .hsync(hsync),
        .vsync(vsync), .rgb(rgb), .is_listening(is_listening), .apple_bite(apple_bite)
    );

    always #5 clk = ~clk;

    // Clock number since reset release: pixel (x,y) of frame f shows at f*F+y*H+x+1
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    function automatic logic [19:0] pt(input int x, input int y);
        return {10'(x), 10'(y)};
    endfunction

    function automatic int unsigned kp(input int f, input int x, input int y);
        return int'(F) * f + y * int'(H) + x + 1;
    endfunction

    function automatic logic [11:0] sample(input int sig);
        case (sig)
            SIG_HS:  return 12'(hsync);
            SIG_VS:  return 12'(vsync);
            SIG_RGB: return rgb;
            SIG_LIS: return 12'(is_listening);
            default: return 12'(apple_bite);
        endcase
    endfunction

    task automatic expect_at(input int unsigned c, input int sig, input logic [11:0] v,
                             input string name);
        chk_t e;
        e.cyc = c; e.sig = sig; e.exp = v; e.name = name;
        sb.push_back(e);
    endtask

    task automatic reset_checks();
        expect_at(0, SIG_HS, 12'h0, "rst_hsync");
        expect_at(0, SIG_VS, 12'h0, "rst_vsync");
        expect_at(0, SIG_RGB, 12'h0, "rst_rgb");
        expect_at(0, SIG_LIS, 12'h0, "rst_listen");
        expect_at(0, SIG_BITE, 12'h0, "rst_bite");
    endtask

    task automatic go_to(input int unsigned n);
        int unsigned guard = 0;
        while (cyc != n && guard < 60000) begin
            @(posedge clk); #2;
            guard++;
        end
        if (cyc != n) begin
            total++; bad++;
            $display("FAIL go_to timeout: at clock %0d, wanted %0d", cyc, n);
        end
    endtask

    // Monitor: compare every due entry on the falling edge
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                total++;
                if (sample(sb[i].sig) !== sb[i].exp) begin
                    bad++;
                    $display("FAIL %s clock=%0d got=%h want=%h", sb[i].name, cyc,
                             sample(sb[i].sig), sb[i].exp);
                end
                sb.delete(i);
            end else if (sb[i].cyc < cyc) begin
                total++; bad++;
                $display("FAIL %s missed clock=%0d now=%0d want=%h", sb[i].name,
                         sb[i].cyc, cyc, sb[i].exp);
                sb.delete(i);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at clock %0d", cyc);
        $fatal(1);
    end

    initial begin
        int unsigned guard;
        rst = 1'b1; snake_head = pt(10, 20); apple_pos = pt(10, 5);
        vis_apple = 1'b1; hCol = 1'b1; points = 4'd5;
        reset_checks();
        repeat (3) begin @(posedge clk); #2; end
        rst = 1'b0;

        // Frame 0: sync timing and drawing priority, no collision
        expect_at(44, SIG_HS, 12'h0, "hs_before");
        expect_at(45, SIG_HS, 12'h1, "hs_rise");
        expect_at(50, SIG_HS, 12'h1, "hs_last");
        expect_at(51, SIG_HS, 12'h0, "hs_fall");
        expect_at(101, SIG_HS, 12'h1, "hs_period");
        expect_at(1792, SIG_VS, 12'h0, "vs_before");
        expect_at(1793, SIG_VS, 12'h1, "vs_rise");
        expect_at(1904, SIG_VS, 12'h1, "vs_last");
        expect_at(1905, SIG_VS, 12'h0, "vs_fall");
        expect_at(LAT - 1, SIG_LIS, 12'h0, "lis_before");
        expect_at(LAT, SIG_LIS, 12'h1, "lis_rise");
        expect_at(F, SIG_LIS, 12'h1, "lis_last");
        expect_at(F + 1, SIG_LIS, 12'h0, "lis_fall");
        expect_at(LAT, SIG_BITE, 12'h0, "bite_none_f0");
        expect_at(kp(0, 11, 21), SIG_RGB, 12'h0F0, "head_px");
        expect_at(kp(0, 13, 23), SIG_RGB, 12'h0F0, "head_corner");
        expect_at(kp(0, 14, 23), SIG_RGB, 12'h000, "head_right_edge");
        expect_at(kp(0, 13, 24), SIG_RGB, 12'h000, "head_bottom_edge");
        expect_at(kp(0, 11, 6), SIG_RGB, 12'hF00, "apple_px");
        expect_at(kp(0, 12, 5), SIG_RGB, 12'hF00, "apple_over_bar");
        expect_at(kp(0, 5, 5), SIG_RGB, 12'hFFF, "bar_px");
        expect_at(kp(0, 9, 9), SIG_RGB, 12'hFFF, "bar_corner");
        expect_at(kp(0, 10, 9), SIG_RGB, 12'h000, "bar_right_edge");
        expect_at(kp(0, 9, 10), SIG_RGB, 12'h000, "bar_bottom_edge");
        expect_at(kp(0, 20, 5), SIG_RGB, 12'h000, "black_px");

        // Frames 1-4: overlapping head and apple, hCol held low
        go_to(1700);
        snake_head = pt(10, 20); apple_pos = pt(12, 22); hCol = 1'b0;
        expect_at(kp(1, 12, 22), SIG_RGB, 12'h0F0, "overlap_head_wins");
        expect_at(kp(1, 15, 25), SIG_RGB, 12'hF00, "overlap_apple_px");
        expect_at(F + LAT - 1, SIG_BITE, 12'h0, "bite_before_vblank");
        expect_at(F + LAT, SIG_BITE, 12'h1, "bite_rise");
        expect_at(3 * F + LAT, SIG_BITE, 12'h1, "bite_hold_f3");
        expect_at(4 * F + LAT, SIG_BITE, 12'h1, "bite_hold_f4");
        expect_at(9800, SIG_BITE, 12'h1, "bite_before_hcol");
        expect_at(9801, SIG_BITE, 12'h0, "bite_cleared");
        go_to(9800);
        hCol = 1'b1; snake_head = pt(10, 20); apple_pos = pt(10, 5);
        go_to(9810);
        hCol = 1'b0;
        expect_at(9811, SIG_BITE, 12'h0, "hcol_fall_noop");
        expect_at(5 * F + LAT, SIG_BITE, 12'h0, "nocol_f5");
        expect_at(6 * F + LAT, SIG_BITE, 12'h0, "nocol_f6");
        expect_at(7 * F + LAT, SIG_BITE, 12'h0, "nocol_f7");

        // Frame 8: hidden apple still collides
        go_to(15900);
        snake_head = pt(20, 15); apple_pos = pt(22, 17); vis_apple = 1'b0;
        expect_at(kp(8, 21, 16), SIG_RGB, 12'h0F0, "hidden_head_px");
        expect_at(kp(8, 24, 19), SIG_RGB, 12'h000, "hidden_apple_px");
        expect_at(8 * F + LAT - 1, SIG_BITE, 12'h0, "hidden_bite_before");
        expect_at(8 * F + LAT, SIG_BITE, 12'h1, "hidden_bite");

        // Frame 9: hCol rises on the latch clock, clear wins
        go_to(17850);
        hCol = 1'b1;
        expect_at(17851, SIG_BITE, 12'h0, "bite_cleared2");
        go_to(17860);
        hCol = 1'b0;
        expect_at(9 * F + LAT - 1, SIG_BITE, 12'h0, "race_before");
        expect_at(9 * F + LAT, SIG_BITE, 12'h0, "race_bite");
        expect_at(9 * F + LAT, SIG_LIS, 12'h1, "race_listen");
        expect_at(10 * F + LAT, SIG_BITE, 12'h1, "after_race_bite");
        go_to(9 * F + LAT - 1);
        hCol = 1'b1;

        // Frame 11: visible-region clipping, full score, sticky bite
        go_to(21900);
        snake_head = pt(38, 28); apple_pos = pt(0, 0); vis_apple = 1'b1; points = 4'd15;
        expect_at(kp(11, 1, 1), SIG_RGB, 12'hF00, "apple_corner_px");
        expect_at(kp(11, 29, 9), SIG_RGB, 12'hFFF, "bar15_last");
        expect_at(kp(11, 30, 9), SIG_RGB, 12'h000, "bar15_edge");
        expect_at(kp(11, 39, 29), SIG_RGB, 12'h0F0, "head_clip_in");
        expect_at(kp(11, 40, 29), SIG_RGB, 12'h000, "head_clip_out");
        expect_at(11 * F + 100, SIG_BITE, 12'h1, "bite_sticky_mid");
        expect_at(11 * F + LAT, SIG_BITE, 12'h1, "bite_sticky_f11");

        // Reset in vblank, then timing restarts from line 0
        go_to(24000);
        rst = 1'b1;
        @(posedge clk); #2;
        reset_checks();
        @(posedge clk); #2;
        rst = 1'b0;
        expect_at(44, SIG_HS, 12'h0, "rr_hs_before");
        expect_at(45, SIG_HS, 12'h1, "rr_hs_rise");
        expect_at(kp(0, 1, 1), SIG_RGB, 12'hF00, "rr_apple_px");
        expect_at(LAT - 1, SIG_LIS, 12'h0, "rr_lis_before");
        expect_at(LAT, SIG_LIS, 12'h1, "rr_lis_rise");
        expect_at(LAT, SIG_BITE, 12'h0, "rr_bite");

        go_to(1800);
        guard = 0;
        while (sb.size() != 0 && guard < 5000) begin
            @(posedge clk); #2;
            guard++;
        end
        foreach (sb[i]) begin
            total++; bad++;
            $display("FAIL %s never checked: due clock=%0d want=%h", sb[i].name,
                     sb[i].cyc, sb[i].exp);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
